pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Generic elastic pipeline stage register. It is the parametrised successor of the fixed-field stage registers used between the IF/ID/EX/MEM/WB stages.
- Carries an opaque DATA_W-bit payload; stages pack and unpack their own fields.
- Adds a valid/ready handshake, stall via back-pressure, and a flush that inserts a bubble.
- Optional skid buffer breaks the ready path so the stage sustains full throughput.

Parameters:
DATA_W, 32, payload width in bits (>=1)
CLEAR_DATA, 1, 1: flush/reset zero the payload registers; 0: only valid bits are cleared
RESET_DATA, 0, payload value loaded on reset/flush when CLEAR_DATA=1 (DATA_W bits)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
flush  in  1  synchronous bubble insert; discards all held and incoming beats
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat
in_data  in  DATA_W  upstream payload
out_valid  out  1  downstream beat valid
out_ready  in  1  downstream accepts beat
out_data  out  DATA_W  downstream payload (registered)
occ  out  2  beats held: 0, 1 or 2 (2 only with skid)

Behaviour:
- One clock and synchronous active-high reset; all state changes on the rising edge of clk.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Priority each edge: reset > flush > normal operation.
- Reset: out_valid=0, occ=0, skid empty, in_ready=0 while reset is high. out_data=RESET_DATA if CLEAR_DATA=1, else unchanged.
- Flush: out_valid=0, skid emptied, occ=0. A beat with in_fire in the flush cycle is dropped and counts as consumed upstream. Payload handling follows CLEAR_DATA. in_ready is 1 in the cycle after flush.
- Latency: an accepted beat appears on out_data/out_valid on the next edge. There is no combinational in-to-out path.
- Ordering is strictly FIFO. No beat is duplicated or lost except by flush/reset.
- out_data and out_valid stay stable while out_valid=1 and out_ready=0.
- Without the skid option (single register):
  - in_ready = ~reset & (~out_valid | out_ready), combinational.
  - in_fire loads the main register and sets out_valid.
  - out_fire without in_fire clears out_valid.
  - Simultaneous in_fire and out_fire: the new beat replaces the old beat with no bubble.
- occ = out_valid (+ skid valid when the skid option is built).

Optional Feature:
PIPE_SKID_EN
- Defined: adds a one-entry skid register. in_ready is a registered signal equal to ~skid_valid, with no path from out_ready.
- Skid-mode states:
  - EMPTY (occ 0): in_fire -> BUSY.
  - BUSY (occ 1):
    - in_fire & ~out_fire -> FULL; the incoming beat goes to skid.
    - out_fire & ~in_fire -> EMPTY.
    - Both -> BUSY; main loads in_data.
  - FULL (occ 2): in_ready=0; out_fire -> BUSY, main <= skid.
- Sustains 1 beat/cycle under continuous ready. Absorbs a beat accepted in the same cycle out_ready drops.
- Flush/reset empty both entries.
- Undefined: single register only. in_ready is combinational as above; occ never exceeds 1; the skid logic is absent.

Test Plan:
- Reset: hold reset 3 cycles with in_valid=1, in_data=0xA5 -> in_ready=0, out_valid=0, occ=0, out_data=0 (CLEAR_DATA=1). First edge after release accepts nothing; in_ready=1 on the next cycle.
- Streaming: out_ready=1, send 0x1..0x8 back-to-back -> out_data 0x1..0x8 on 8 consecutive cycles, 1 cycle after each input, with no bubbles.
- Back-pressure:
  - Stream 0x10,0x11,0x12 and drop out_ready for 3 cycles after the first output -> out_data held at 0x10 with out_valid=1.
  - Without skid: in_ready=0 while full.
  - With skid: 0x11 goes into skid, occ=2, in_ready=0.
  - After release, outputs are 0x10,0x11,0x12 in order.
- Flush mid-stream: occ=2 (skid build) or 1, assert flush together with in_fire of 0x55 -> next cycle out_valid=0, occ=0, in_ready=1, out_data=0. 0x55 never appears.
- Reset beats flush: assert reset and flush together while holding 0x77 -> same result as reset alone; the next accepted beat 0x78 emerges alone.
- Random: random in_valid/out_ready for 10k cycles against a scoreboard FIFO -> order preserved, no loss or duplication, out_data stable whenever out_valid & ~out_ready.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: opaque payload, valid/ready handshake, flush-to-bubble.
// Define PIPE_SKID_EN to add a one-entry skid buffer that registers in_ready.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W     = 32,
  parameter bit                CLEAR_DATA = 1'b1,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  logic              w_in_fire;
  logic              w_out_fire;
  logic [DATA_W-1:0] r_main;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign out_data   = r_main;

`ifdef PIPE_SKID_EN

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_in_ready;
  logic [DATA_W-1:0] r_skid;
  logic              w_main_ld_in;
  logic              w_main_ld_skid;
  logic              w_skid_ld;

  always_comb begin
    w_state_nxt    = r_state;
    w_main_ld_in   = 1'b0;
    w_main_ld_skid = 1'b0;
    w_skid_ld      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt  = ST_BUSY;
          w_main_ld_in = 1'b1;
        end
      end
      ST_BUSY: begin
        if (w_in_fire && w_out_fire) begin
          w_main_ld_in = 1'b1;
        end else if (w_in_fire) begin
          w_state_nxt = ST_FULL;
          w_skid_ld   = 1'b1;
        end else if (w_out_fire) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_out_fire) begin
          w_state_nxt    = ST_BUSY;
          w_main_ld_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // in_ready is precomputed from the next state so out_ready never reaches it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b0;
      if (CLEAR_DATA) begin
        r_main <= RESET_DATA;
        r_skid <= RESET_DATA;
      end
    end else if (flush) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
      if (CLEAR_DATA) begin
        r_main <= RESET_DATA;
        r_skid <= RESET_DATA;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
      if (w_main_ld_in) begin
        r_main <= in_data;
      end else if (w_main_ld_skid) begin
        r_main <= r_skid;
      end
      if (w_skid_ld) begin
        r_skid <= in_data;
      end
    end
  end

  assign in_ready  = r_in_ready & ~reset;
  assign out_valid = (r_state != ST_EMPTY);
  assign occ       = 2'(r_state);

`else

  logic r_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      if (CLEAR_DATA) begin
        r_main <= RESET_DATA;
      end
    end else if (flush) begin
      r_valid <= 1'b0;
      if (CLEAR_DATA) begin
        r_main <= RESET_DATA;
      end
    end else if (w_in_fire) begin
      r_main  <= in_data;
      r_valid <= 1'b1;
    end else if (w_out_fire) begin
      r_valid <= 1'b0;
    end
  end

  assign in_ready  = ~reset & (~r_valid | out_ready);
  assign out_valid = r_valid;
  assign occ       = {1'b0, r_valid};

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; expectations follow PIPE_SKID_EN when defined.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occ;

  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] sb[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W    (DW),
    .CLEAR_DATA(1'b1),
    .RESET_DATA('0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occ      (occ)
  );

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 32'hA5, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (occ !== 2'd0) begin bad++; $display("FAIL rst_occ: got %0d want 0", occ); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    next_cycle();
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    next_cycle();
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_release_valid: got %b want 0", out_valid); end
    sb.delete();
    next_cycle();
  endtask

  task automatic test_streaming();
    logic [DW-1:0] exp;
    for (int cyc = 0; cyc < 12; cyc++) begin
      drive(cyc < 8, DW'(cyc + 1), 1'b1, 1'b0);
      @(negedge clk);
      total++;
      if (out_valid !== ((cyc >= 1) && (cyc <= 8))) begin
        bad++; $display("FAIL stream_valid cyc%0d: got %b want %b", cyc, out_valid, (cyc >= 1) && (cyc <= 8));
      end
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL stream_extra: got %h want none", out_data);
        end else begin
          exp = sb.pop_front();
          if (out_data !== exp) begin bad++; $display("FAIL stream_data: got %h want %h", out_data, exp); end
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] src[3] = '{32'h10, 32'h11, 32'h12};
    logic [DW-1:0] exp;
    logic [1:0]    exp_full;
    int            idx = 0;
`ifdef PIPE_SKID_EN
    exp_full = 2'd2;
`else
    exp_full = 2'd1;
`endif
    for (int cyc = 0; cyc < 10; cyc++) begin
      drive(idx < 3, (idx < 3) ? src[idx] : '0, !((cyc >= 1) && (cyc <= 3)), 1'b0);
      @(negedge clk);
      if ((cyc >= 1) && (cyc <= 3)) begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid cyc%0d: got %b want 1", cyc, out_valid); end
        total++; if (out_data !== 32'h10) begin bad++; $display("FAIL bp_hold_data cyc%0d: got %h want 10", cyc, out_data); end
      end
      if ((cyc >= 2) && (cyc <= 3)) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc%0d: got %b want 0", cyc, in_ready); end
        total++; if (occ !== exp_full) begin bad++; $display("FAIL bp_occ cyc%0d: got %0d want %0d", cyc, occ, exp_full); end
      end
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL bp_extra: got %h want none", out_data);
        end else begin
          exp = sb.pop_front();
          if (out_data !== exp) begin bad++; $display("FAIL bp_order: got %h want %h", out_data, exp); end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(in_data);
        idx++;
      end
      next_cycle();
    end
    total++; if (idx != 3) begin bad++; $display("FAIL bp_accepted: got %0d want 3", idx); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL bp_drained: got %0d left want 0", sb.size()); end
  endtask

  task automatic test_flush();
    logic [1:0] exp_full;
`ifdef PIPE_SKID_EN
    exp_full = 2'd2;
`else
    exp_full = 2'd1;
`endif
    drive(1'b1, 32'h20, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 32'h21, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 32'h55, 1'b1, 1'b1);
    @(negedge clk);
    total++; if (occ !== exp_full) begin bad++; $display("FAIL flush_pre_occ: got %0d want %0d", occ, exp_full); end
    next_cycle();
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    total++; if (occ !== 2'd0) begin bad++; $display("FAIL flush_occ: got %0d want 0", occ); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL flush_data: got %h want 0", out_data); end
    sb.delete();
    for (int cyc = 0; cyc < 3; cyc++) begin
      next_cycle();
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_leak cyc%0d: got %b data %h want 0", cyc, out_valid, out_data); end
    end
    next_cycle();
  endtask

  task automatic test_reset_flush();
    drive(1'b1, 32'h77, 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    drive(1'b1, 32'h77, 1'b0, 1'b1);
    next_cycle();
    reset = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rf_valid: got %b want 0", out_valid); end
    total++; if (occ !== 2'd0) begin bad++; $display("FAIL rf_occ: got %0d want 0", occ); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rf_data: got %h want 0", out_data); end
    sb.delete();
    next_cycle();
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rf_in_ready: got %b want 1", in_ready); end
    next_cycle();
    drive(1'b1, 32'h78, 1'b1, 1'b0);
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rf_accept: got %b want 1", in_ready); end
    next_cycle();
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rf_out_valid: got %b want 1", out_valid); end
    total++; if (out_data !== 32'h78) begin bad++; $display("FAIL rf_out_data: got %h want 78", out_data); end
    next_cycle();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rf_alone: got %b data %h want 0", out_valid, out_data); end
    next_cycle();
  endtask

  task automatic test_random();
    logic [DW-1:0] exp;
    logic [DW-1:0] prev_data = '0;
    logic          prev_hold = 1'b0;
    logic          exp_ready;
    for (int cyc = 0; cyc < 10004; cyc++) begin
      if (cyc < 10000)
        drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6, 1'b0);
      else
        drive(1'b0, '0, 1'b1, 1'b0);
      @(negedge clk);
`ifdef PIPE_SKID_EN
      exp_ready = (sb.size() < 2);
`else
      exp_ready = (sb.size() == 0) || out_ready;
`endif
      total++; if (occ !== 2'(sb.size())) begin bad++; $display("FAIL rnd_occ cyc%0d: got %0d want %0d", cyc, occ, sb.size()); end
      total++; if (in_ready !== exp_ready) begin bad++; $display("FAIL rnd_in_ready cyc%0d: got %b want %b", cyc, in_ready, exp_ready); end
      if (prev_hold) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          bad++; $display("FAIL rnd_stable cyc%0d: got %b/%h want 1/%h", cyc, out_valid, out_data, prev_data);
        end
      end
      prev_hold = out_valid & ~out_ready;
      prev_data = out_data;
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL rnd_extra cyc%0d: got %h want none", cyc, out_data);
        end else begin
          exp = sb.pop_front();
          if (out_data !== exp) begin bad++; $display("FAIL rnd_order cyc%0d: got %h want %h", cyc, out_data, exp); end
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
      next_cycle();
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL rnd_lost: got %0d left want 0", sb.size()); end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_reset_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
